// File: rtl/spec_free_list.sv
`default_nettype none
// spec_free_list: circular free list of physical register tags feeding rename (rev 1.0).
// Up to four pops and four commit releases per cycle; recovery snaps head back to tail.
module spec_free_list #(
  parameter int SIZE_PHYSICAL_TABLE = 96,
  parameter int SIZE_PHYSICAL_LOG   = 7,
  parameter int SIZE_RMT            = 32,
  parameter int SIZE_FREE_LIST      = 64,
  parameter int SIZE_FREE_LIST_LOG  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          popValid0_i,
  input  logic                          popValid1_i,
  input  logic                          popValid2_i,
  input  logic                          popValid3_i,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]  freePhyReg3_o,
  output logic                          freeListEmpty_o,
  output logic [SIZE_FREE_LIST_LOG:0]   freeCnt_o,
  input  logic                          releasedValid0_i,
  input  logic                          releasedValid1_i,
  input  logic                          releasedValid2_i,
  input  logic                          releasedValid3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]  releasedPhyMap3_i,
  input  logic                          recoverFlag_i
);

  localparam int PTR_W = SIZE_FREE_LIST_LOG;
  localparam int CNT_W = SIZE_FREE_LIST_LOG + 1;
  localparam int TAG_W = SIZE_PHYSICAL_LOG;

  if ((SIZE_FREE_LIST != SIZE_PHYSICAL_TABLE - SIZE_RMT) ||
      (SIZE_FREE_LIST != (1 << SIZE_FREE_LIST_LOG))) begin : g_size_check
    $error("spec_free_list: inconsistent free-list sizing");
  end

  logic [TAG_W-1:0] list_q [SIZE_FREE_LIST];
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0] freeCnt_q, freeCnt_d;

  logic [3:0]       popVld;
  logic [3:0]       relVld;
  logic [TAG_W-1:0] relTag [4];
  logic [TAG_W-1:0] popTag [4];
  logic [2:0]       popOff [4];
  logic [2:0]       relOff [4];
  logic [2:0]       nPop;
  logic [2:0]       nPush;
  logic [2:0]       nPopEff;
  logic             empty;

  assign popVld    = {popValid3_i, popValid2_i, popValid1_i, popValid0_i};
  assign relVld    = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
  assign relTag[0] = releasedPhyMap0_i;
  assign relTag[1] = releasedPhyMap1_i;
  assign relTag[2] = releasedPhyMap2_i;
  assign relTag[3] = releasedPhyMap3_i;

  // Each active slot's offset is the number of active slots below it (compaction).
  always_comb begin
    popOff[0] = '0;
    relOff[0] = '0;
    for (int k = 1; k < 4; k++) begin
      popOff[k] = popOff[k-1] + 3'(popVld[k-1]);
      relOff[k] = relOff[k-1] + 3'(relVld[k-1]);
    end
    nPop  = popOff[3] + 3'(popVld[3]);
    nPush = relOff[3] + 3'(relVld[3]);
    for (int k = 0; k < 4; k++) begin
      popTag[k] = list_q[headPtr_q + PTR_W'(popOff[k])];
    end
  end

  assign empty   = (freeCnt_q < CNT_W'(4));
  assign nPopEff = empty ? 3'd0 : nPop;

  always_comb begin
    headPtr_d = headPtr_q + PTR_W'(nPopEff);
    tailPtr_d = tailPtr_q + PTR_W'(nPush);
    freeCnt_d = freeCnt_q + CNT_W'(nPush) - CNT_W'(nPopEff);
    // Everything popped since the last release is still in [tail, head); rewinding head frees it.
    if (recoverFlag_i) begin
      headPtr_d = tailPtr_q;
      tailPtr_d = tailPtr_q;
      freeCnt_d = CNT_W'(SIZE_FREE_LIST);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      freeCnt_q <= CNT_W'(SIZE_FREE_LIST);
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        list_q[i] <= TAG_W'(SIZE_RMT + i);
      end
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      freeCnt_q <= freeCnt_d;
      if (!recoverFlag_i) begin
        for (int k = 0; k < 4; k++) begin
          if (relVld[k]) begin
            list_q[tailPtr_q + PTR_W'(relOff[k])] <= relTag[k];
          end
        end
      end
    end
  end

  assign freePhyReg0_o   = popTag[0];
  assign freePhyReg1_o   = popTag[1];
  assign freePhyReg2_o   = popTag[2];
  assign freePhyReg3_o   = popTag[3];
  assign freeListEmpty_o = empty;
  assign freeCnt_o       = freeCnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spec_free_list.sv
`default_nettype none
// tb_spec_free_list: directed stimulus against a circular-buffer model of the free list,
// compared every cycle, plus literal expectations from the test plan.
module tb_spec_free_list;
  localparam int FL  = 64;
  localparam int RMT = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pv;
  logic [3:0] rv;
  logic [6:0] rt [4];
  logic       rec;
  logic [6:0] fr [4];
  logic       fl_empty;
  logic [6:0] cnt;

  always #5 clk = ~clk;

  spec_free_list dut (
    .clk              (clk),
    .reset            (reset),
    .popValid0_i      (pv[0]),
    .popValid1_i      (pv[1]),
    .popValid2_i      (pv[2]),
    .popValid3_i      (pv[3]),
    .freePhyReg0_o    (fr[0]),
    .freePhyReg1_o    (fr[1]),
    .freePhyReg2_o    (fr[2]),
    .freePhyReg3_o    (fr[3]),
    .freeListEmpty_o  (fl_empty),
    .freeCnt_o        (cnt),
    .releasedValid0_i (rv[0]),
    .releasedValid1_i (rv[1]),
    .releasedValid2_i (rv[2]),
    .releasedValid3_i (rv[3]),
    .releasedPhyMap0_i(rt[0]),
    .releasedPhyMap1_i(rt[1]),
    .releasedPhyMap2_i(rt[2]),
    .releasedPhyMap3_i(rt[3]),
    .recoverFlag_i    (rec)
  );

  int m_arr [FL];
  int m_head, m_tail, m_cnt;
  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  function automatic int pc_below(input logic [3:0] v, input int k);
    int c = 0;
    for (int i = 0; i < k; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int m_tag(input int k);
    return m_arr[(m_head + pc_below(pv, k)) % FL];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Model: free tags live in slots head..head+cnt-1 of a 64-entry ring.
  always @(posedge clk or negedge reset) begin : model
    int np;
    int j;
    if (!reset) begin
      for (int i = 0; i < FL; i++) m_arr[i] = RMT + i;
      m_head = 0;
      m_tail = 0;
      m_cnt  = FL;
    end else if (rec) begin
      m_head = m_tail;
      m_cnt  = FL;
    end else begin
      np = (m_cnt < 4) ? 0 : pc_below(pv, 4);
      j  = 0;
      for (int k = 0; k < 4; k++) begin
        if (rv[k]) begin
          m_arr[(m_tail + j) % FL] = int'(rt[k]);
          j++;
        end
      end
      m_head = (m_head + np) % FL;
      m_tail = (m_tail + j) % FL;
      m_cnt  = m_cnt + j - np;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_cnt", int'(cnt), m_cnt);
      chk("cyc_empty", int'(fl_empty), (m_cnt < 4) ? 1 : 0);
      for (int k = 0; k < 4; k++) chk($sformatf("cyc_tag%0d", k), int'(fr[k]), m_tag(k));
    end
  end

  task automatic drive(input logic [3:0] p, input logic [3:0] r,
                       input int t0, input int t1, input int t2, input int t3, input logic rc);
    pv = p; rv = r; rec = rc;
    rt[0] = 7'(t0); rt[1] = 7'(t1); rt[2] = 7'(t2); rt[3] = 7'(t3);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  int         alloc [$];
  int         rtv [4];
  logic [3:0] p, r;
  bit         seen [128];
  int         nseen;
  int         t;

  initial begin
    reset = 1'b0;
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    chk("rst_tag0", int'(fr[0]), 32);
    chk("rst_tag1", int'(fr[1]), 33);
    chk("rst_tag2", int'(fr[2]), 34);
    chk("rst_tag3", int'(fr[3]), 35);
    chk("rst_cnt", int'(cnt), 64);
    chk("rst_empty", int'(fl_empty), 0);
    cmp_en = 1'b1;
    reset  = 1'b1;

    // Pop all four slots
    tick();
    chk("pop4_tag0", int'(fr[0]), 36);
    chk("pop4_tag3", int'(fr[3]), 39);
    chk("pop4_cnt", int'(cnt), 60);

    // Sparse pop on slots 1 and 3
    do_reset();
    drive(4'b1010, 4'b0000, 0, 0, 0, 0, 1'b0);
    chk("sparse_tag1", int'(fr[1]), 32);
    chk("sparse_tag3", int'(fr[3]), 33);
    tick();
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    chk("sparse_cnt", int'(cnt), 62);
    chk("sparse_head", int'(fr[0]), 34);

    // Drain to 3, stall, then refill across the wrap point
    do_reset();
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    repeat (15) tick();
    drive(4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    chk("drain_cnt", int'(cnt), 3);
    chk("drain_empty", int'(fl_empty), 1);
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    chk("stall_cnt", int'(cnt), 3);
    chk("stall_tag0", int'(fr[0]), 93);
    drive(4'b0000, 4'b1010, 0, 5, 0, 7, 1'b0);
    tick();
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    chk("refill_cnt", int'(cnt), 5);
    chk("refill_empty", int'(fl_empty), 0);
    chk("wrap_tag0", int'(fr[0]), 93);
    chk("wrap_tag2", int'(fr[2]), 95);
    chk("wrap_tag3", int'(fr[3]), 5);
    tick();
    chk("wrap_cnt", int'(cnt), 1);
    chk("wrap_next", int'(fr[0]), 7);

    // Churn pops against releases of previously allocated tags; both pointers wrap
    do_reset();
    for (int c = 0; c < 80; c++) begin
      p = 4'((c * 7 + 3) % 16);
      r = 4'((c * 11 + 5) % 16);
      for (int k = 0; k < 4; k++) begin
        rtv[k] = 0;
        if (r[k] && alloc.size() > 0) rtv[k] = alloc.pop_front();
        else r[k] = 1'b0;
      end
      drive(p, r, rtv[0], rtv[1], rtv[2], rtv[3], 1'b0);
      if (m_cnt >= 4)
        for (int k = 0; k < 4; k++) if (p[k]) alloc.push_back(m_tag(k));
      tick();
    end
    while (alloc.size() > 0) begin
      r = 4'b0000;
      for (int k = 0; k < 4; k++) begin
        rtv[k] = 0;
        if (alloc.size() > 0) begin
          rtv[k] = alloc.pop_front();
          r[k] = 1'b1;
        end
      end
      drive(4'b0000, r, rtv[0], rtv[1], rtv[2], rtv[3], 1'b0);
      tick();
    end
    drive(4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);
    chk("churn_cnt", int'(cnt), 64);
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    nseen = 0;
    for (int c = 0; c < 16; c++) begin
      drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        t = int'(fr[k]);
        if (t >= RMT && t < RMT + FL && !seen[t]) nseen++;
        seen[t] = 1'b1;
      end
      tick();
    end
    chk("churn_distinct", nseen, 64);
    chk("churn_final_cnt", int'(cnt), 0);

    // Recovery: 8 pops, 2 releases, then an 8-cycle recovery window
    do_reset();
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    drive(4'b0000, 4'b0011, 5, 7, 0, 0, 1'b0);
    tick();
    drive(4'b1111, 4'b1111, 1, 2, 3, 4, 1'b1);
    tick();
    chk("rec_cnt", int'(cnt), 64);
    chk("rec_tag0", int'(fr[0]), 34);
    chk("rec_tag3", int'(fr[3]), 37);
    repeat (7) tick();
    chk("rec_hold_cnt", int'(cnt), 64);
    chk("rec_hold_tag1", int'(fr[1]), 35);
    drive(4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    tick();
    chk("post_rec_cnt", int'(cnt), 60);
    chk("post_rec_tag0", int'(fr[0]), 38);

    // Asynchronous reset between edges mid-burst
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_tag0", int'(fr[0]), 32);
    chk("async_tag3", int'(fr[3]), 35);
    chk("async_cnt", int'(cnt), 64);
    chk("async_empty", int'(fl_empty), 0);
    tick();
    reset = 1'b1;
    tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
